aes_block_fifo: RTL and testbench
=================================

Name: aes_block_fifo

Overview:
- Parametrised synchronous FIFO that buffers AES blocks between the UART receive shift register and the AES core. It is the successor to the fixed 7-entry, 128-bit block buffer.
- Adds the following over that buffer:
  - configurable width and depth;
  - valid/ready handshakes with single-cycle push/pop, including simultaneous push and pop;
  - occupancy count and programmable almost-full/almost-empty flags;
  - synchronous flush;
  - sticky overflow/underflow error flags.

Parameters:
- DATA_W, 128, bits per entry (one AES block).
- DEPTH, 8, number of entries; power of two, >= 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  synchronous clear of contents and error flags.
- din  in  DATA_W  write data.
- in_valid  in  1  producer offers din.
- in_ready  out  1  FIFO accepts din this cycle.
- dout  out  DATA_W  head-of-queue data (first-word-fall-through).
- out_valid  out  1  dout holds a valid entry.
- out_ready  in  1  consumer takes dout this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: in_valid was seen while in_ready=0.
- underflow  out  1  sticky: out_ready was seen while out_valid=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Resulting outputs: in_ready=1, out_valid=0, almost_empty=1, almost_full=0 (given AF_LEVEL>0).
  - Storage array is not reset. dout is don't-care while out_valid=0.
  - Reset asserted mid-transfer discards all contents immediately.
  - Deassertion is taken synchronously to clk by the parent.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH); registered-state only, with no combinational dependence on out_ready.
  - out_valid = (count != 0).
- Push: mem[wr_ptr] <= din on the clk edge; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH. dout = mem[rd_ptr], combinational from the pointer (FWFT).
- Latency: an entry pushed at edge N is visible on dout with out_valid=1 after edge N (i.e. in cycle N+1) when the FIFO was empty.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Full with out_ready=1 and in_valid=1: only the pop occurs, since in_ready=0. The next cycle has count=DEPTH-1 and in_ready=1.
- Empty with in_valid=1 and out_ready=1: only the push occurs, and underflow is set because out_ready was seen with out_valid=0.
- Simultaneous push and pop at 0 < count < DEPTH: both occur and count is unchanged.
- Pointers wrap from DEPTH-1 to 0; no other wrap handling is needed because count disambiguates full from empty.
- overflow sets on any cycle with in_valid=1 & in_ready=0. That data is dropped and the FIFO state is unaffected.
- underflow sets on any cycle with out_ready=1 & out_valid=0.
- overflow and underflow are sticky; they clear only on reset or flush.
- flush=1 at a clk edge:
  - pointers, count and both error flags go to 0;
  - any push or pop in the same cycle is ignored;
  - in_ready stays 1 during flush.
- almost_full and almost_empty are combinational from count.

Test Plan:
- Reset then idle, with DEPTH=8 -> in_ready=1, out_valid=0, count=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Push 0x...01 through 0x...08 (one per cycle, out_ready=0) -> count steps 1..8; almost_full rises when count=6; in_ready=0 at count=8; dout=0x...01 throughout.
- From full, hold in_valid=1 with din=0x...AA for one cycle -> overflow=1 and stays 1; count=8; the AA word never appears on dout.
- From full, pop 8 times with out_ready=1 -> dout sequence 0x...01..0x...08 in order; count reaches 0; out_valid=0 after the 8th pop; a further out_ready=1 sets underflow=1.
- Push 5 entries, then drive in_valid=1 and out_ready=1 continuously for 20 cycles with incrementing din -> count stays 5; output order matches input order across pointer wrap.
- Push 3 entries and set overflow, then pulse flush with in_valid=1 -> count=0, out_valid=0, overflow=0, and the flush-cycle din is not stored. Separately, assert reset=0 mid-burst -> count=0 immediately, with no clk edge required.

Source files
------------

// File: rtl/aes_block_fifo.sv
// ---------------------------------------------------------------------------
// aes_block_fifo
//
// Synchronous first-word-fall-through FIFO that buffers AES blocks between
// the UART receive shift register and the AES core.
//
// Parameters:
//   DATA_W   - bits per entry (one AES block)
//   DEPTH    - number of entries, power of two, >= 2
//   AF_LEVEL - almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL - almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   flush        in   synchronous clear of contents and error flags
//   din          in   write data
//   in_valid     in   producer offers din
//   in_ready     out  FIFO accepts din this cycle
//   dout         out  head-of-queue data (valid while out_valid=1)
//   out_valid    out  dout holds a valid entry
//   out_ready    in   consumer takes dout this cycle
//   count        out  current occupancy, 0..DEPTH
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   overflow     out  sticky: in_valid seen while in_ready=0
//   underflow    out  sticky: out_ready seen while out_valid=0
// ---------------------------------------------------------------------------
module aes_block_fifo #(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [DATA_W-1:0]      din,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      dout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  wr_en;
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // A flush cycle swallows any transfer offered alongside it.
    assign push = in_valid & ~full & ~flush;
    assign pop  = out_ready & ~empty & ~flush;

    // Storage: one register per entry, no reset so it maps onto plain
    // flops / distributed RAM. Only the addressed entry is enabled.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            assign wr_en[gi] = push & (wr_ptr_reg == PTR_W'(gi));

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    entry_reg <= din;
                end
            end

            assign mem_q[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer rollover is the
            // modulo-DEPTH wrap; count tells full apart from empty.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
            overflow_next  = overflow_reg | (in_valid & full);
            underflow_next = underflow_reg | (out_ready & empty);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // in_ready depends only on registered state (plus flush, which keeps the
    // producer from seeing a stall while the FIFO is being cleared).
    assign in_ready     = ~full | flush;
    assign out_valid    = ~empty;
    assign dout         = mem_q[rd_ptr_reg];
    assign count        = count_reg;
    assign almost_full  = (count_reg >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_reg <= CNT_W'(AE_LEVEL));
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_aes_block_fifo.sv
// ---------------------------------------------------------------------------
// tb_aes_block_fifo
//
// Self-checking bench for aes_block_fifo (DATA_W=128, DEPTH=8). A queue-based
// reference model tracks contents and sticky flags; every cycle all outputs
// are compared against it. Directed sequences cover fill, overflow, drain,
// underflow, streaming across pointer wrap, flush and asynchronous reset,
// followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_aes_block_fifo;

    localparam int DATA_W   = 128;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = DEPTH - 2;
    localparam int AE_LEVEL = 1;

    logic              clk;
    logic              reset;
    logic              flush;
    logic [DATA_W-1:0] din;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] dout;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        count;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    aes_block_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .din          (din),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dout         (dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] model_q[$];
    logic              model_ovf;
    logic              model_unf;

    int err_cnt = 0;
    int chk_cnt = 0;
    int txn_cnt = 0;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Compare all outputs against the model for the given inputs.
    task automatic check_outputs(input logic fl);
        int sz;
        sz = model_q.size();
        check_val("count",        DATA_W'(count),        DATA_W'(sz));
        check_val("in_ready",     DATA_W'(in_ready),     DATA_W'((sz != DEPTH) || fl));
        check_val("out_valid",    DATA_W'(out_valid),    DATA_W'(sz != 0));
        check_val("almost_full",  DATA_W'(almost_full),  DATA_W'(sz >= AF_LEVEL));
        check_val("almost_empty", DATA_W'(almost_empty), DATA_W'(sz <= AE_LEVEL));
        check_val("overflow",     DATA_W'(overflow),     DATA_W'(model_ovf));
        check_val("underflow",    DATA_W'(underflow),    DATA_W'(model_unf));
        if (sz != 0) begin
            check_val("dout", dout, model_q[0]);
        end
    endtask

    // One clock cycle: called just after a falling edge. Drives inputs,
    // checks outputs, advances the model, and returns after the next
    // falling edge.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic fl);
        int sz;
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs(fl);
        sz = model_q.size();
        $display("txn %0d: iv=%0b ordy=%0b fl=%0b din=%h count=%0d dout=%h",
                 txn_cnt, iv, ordy, fl, d, count, dout);
        txn_cnt++;
        if (fl) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else begin
            if (iv && sz == DEPTH) model_ovf = 1'b1;
            if (ordy && sz == 0)   model_unf = 1'b1;
            if (ordy && sz != 0)   void'(model_q.pop_front());
            if (iv && sz != DEPTH) model_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [DATA_W-1:0] aa_word;
    logic [DATA_W-1:0] seq_word;

    initial begin
        model_ovf = 1'b0;
        model_unf = 1'b0;
        reset     = 1'b0;
        flush     = 1'b0;
        din       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aa_word   = {16{8'hAA}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset state, idle
        step(1'b0, '0, 1'b0, 1'b0);

        // Fill with 1..8
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DATA_W'(i), 1'b0, 1'b0);
        end

        // Overflow attempt while full; AA must never be stored
        step(1'b1, aa_word, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Drain 8, then underflow
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Push 5, then 20 cycles of simultaneous push/pop across wrap
        seq_word = 128'h100;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq_word, 1'b0, 1'b0);
            seq_word = seq_word + 1;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, seq_word, 1'b1, 1'b0);
            seq_word = seq_word + 1;
        end

        // Flush to empty, push 3, fill to full and provoke overflow,
        // then flush with in_valid=1
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 128'h200 + DATA_W'(i), 1'b0, 1'b0);
        end
        for (int i = 3; i < DEPTH + 1; i++) begin
            step(1'b1, 128'h200 + DATA_W'(i), 1'b0, 1'b0);
        end
        step(1'b1, 128'hDEAD, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) begin
            step(1'b1, rnd_word(), 1'b0, 1'b0);
        end
        in_valid  = 1'b1;
        din       = rnd_word();
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_val("async_rst_count",     DATA_W'(count),     '0);
        check_val("async_rst_out_valid", DATA_W'(out_valid), '0);
        check_val("async_rst_in_ready",  DATA_W'(in_ready),  DATA_W'(1));
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 128'h300, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
